// File: rtl/esc_pwm_pkg.sv
// Shared types and helpers for the ESC/servo PWM driver.
package esc_pwm_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        ESTOP
    } state_e;

    localparam int US_PER_S = 1_000_000;

    // Signed compare, so negative commands land on the lower bound.
    function automatic logic [15:0] clamp_width(
        input logic signed [31:0] v,
        input int                 lo,
        input int                 hi
    );
        if (v < lo) return 16'(lo);
        if (v > hi) return 16'(hi);
        return v[15:0];
    endfunction

endpackage

// File: rtl/esc_pwm_driver_us_tick_gen.sv
// Microsecond prescaler: one-cycle tick every CLOCK_SPEED_HZ/1e6 clocks.
module us_tick_gen
    import esc_pwm_pkg::*;
#(
    parameter int CLOCK_SPEED_HZ = 50_000_000
) (
    input  logic clk_i,
    input  logic rst_i,
    output logic tick_o
);

    localparam int DIV = CLOCK_SPEED_HZ / US_PER_S;
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt_q, cnt_d;

    assign tick_o = (cnt_q == CW'(DIV - 1));

    always_comb begin
        cnt_d = tick_o ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

endmodule

// File: rtl/esc_pwm_driver.sv
// Servo/ESC pulse generator with clamp, mute and latching e-stop.
// Define DUTY_SLEW_EN to limit width change per period to MAX_STEP_US.
module esc_pwm_driver
    import esc_pwm_pkg::*;
#(
    parameter int CLOCK_SPEED_HZ = 50_000_000,
    parameter int PERIOD_US      = 20000,
    parameter int MIN_WIDTH_US   = 100,
    parameter int MAX_WIDTH_US   = 2500,
    parameter int MAX_STEP_US    = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic signed [31:0] duty,
    input  logic               duty_valid,
    input  logic signed [31:0] zero_speed,
    input  logic               mute,
    input  logic               emergency_off,
    input  logic               clear_estop,
    output logic               pwm_out,
    output logic [15:0]        applied_width,
    output logic               period_start,
    output logic               estop_latched
);

    if ((CLOCK_SPEED_HZ % US_PER_S) != 0 || MAX_STEP_US < 1 ||
        PERIOD_US < 2 || PERIOD_US > 65536) begin : g_param_check
        $error("esc_pwm_driver: invalid parameters");
    end

    localparam logic [15:0] LAST_US = 16'(PERIOD_US - 1);
    localparam logic [15:0] MIN_W   = 16'(MIN_WIDTH_US);

    state_e      state_q, state_d;
    logic [15:0] width_q, width_d;
    logic [15:0] target_q, target_d;
    logic [15:0] us_q, us_d;
    logic        started_q, started_d;
    logic        us_tick;
    logic [15:0] nominal, run_w, start_w;

    us_tick_gen #(
        .CLOCK_SPEED_HZ(CLOCK_SPEED_HZ)
    ) u_tick (
        .clk_i (clock),
        .rst_i (reset),
        .tick_o(us_tick)
    );

    function automatic logic [15:0] sat(input logic [15:0] w);
        return (int'(w) >= PERIOD_US) ? LAST_US : w;
    endfunction

`ifdef DUTY_SLEW_EN
    function automatic logic [15:0] approach(
        input logic [15:0] cur,
        input logic [15:0] nom
    );
        logic [15:0] stp;
        stp = 16'(MAX_STEP_US);
        if (nom > cur) return (nom - cur > stp) ? cur + stp : nom;
        if (cur > nom) return (cur - nom > stp) ? cur - stp : nom;
        return cur;
    endfunction
`endif

    // Boundary is the cycle whose edge wraps the counter to zero.
    assign period_start  = us_tick & (~started_q | (us_q == LAST_US));
    assign pwm_out       = (state_q == RUN) && (us_q < width_q);
    assign applied_width = width_q;
    assign estop_latched = (state_q == ESTOP);

    always_comb begin
        started_d = started_q;
        us_d      = us_q;
        if (us_tick) begin
            started_d = 1'b1;
            us_d      = period_start ? 16'd0 : us_q + 16'd1;
        end
    end

    always_comb begin
        target_d = target_q;
        if (duty_valid)
            target_d = clamp_width(duty, MIN_WIDTH_US, MAX_WIDTH_US);
        nominal = mute ? clamp_width(zero_speed, MIN_WIDTH_US, MAX_WIDTH_US)
                       : target_d;
`ifdef DUTY_SLEW_EN
        run_w   = sat(approach(width_q, nominal));
        start_w = sat(approach(MIN_W, nominal));
`else
        run_w   = sat(nominal);
        start_w = sat(MIN_W);
`endif
        state_d = state_q;
        width_d = width_q;
        unique case (state_q)
            IDLE: begin
                if (period_start) begin
                    state_d = RUN;
                    width_d = start_w;
                end
            end
            RUN: begin
                if (period_start) width_d = run_w;
            end
            ESTOP: begin
                width_d = '0;
                if (clear_estop) state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                width_d = '0;
            end
        endcase
        if (emergency_off) begin
            state_d = ESTOP;
            width_d = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            width_q   <= '0;
            target_q  <= '0;
            us_q      <= '0;
            started_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            width_q   <= width_d;
            target_q  <= target_d;
            us_q      <= us_d;
            started_q <= started_d;
        end
    end

endmodule

// File: doc/esc_pwm_driver.md
Name: esc_pwm_driver

Overview:
- Single-channel servo/ESC pulse generator. It sits directly downstream of the per-motor PID controller and consumes its duty result plus the sensor-cycle strobe.
- Produces a fixed-frequency PWM pulse whose high-time is the commanded width in microseconds.
- Adds range clamping, per-period slew limiting, mute-to-neutral and a latching emergency stop.
- The top level instantiates one per motor in place of the generic pwm instance.

Parameters:
- CLOCK_SPEED_HZ, 50_000_000, system clock frequency; must be an integer multiple of 1 MHz.
- PERIOD_US, 20000, PWM period in microseconds (50 Hz).
- MIN_WIDTH_US, 100, lower clamp on commanded pulse width.
- MAX_WIDTH_US, 2500, upper clamp on commanded pulse width.
- MAX_STEP_US, 4, maximum change of applied width per period (slew feature only).

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- duty  in  32  signed commanded pulse width in us (PID result)
- duty_valid  in  1  one-cycle strobe; latches duty
- zero_speed  in  32  signed neutral pulse width in us (used when muted)
- mute  in  1  level; forces neutral pulse
- emergency_off  in  1  level, active-high; trips e-stop
- clear_estop  in  1  one-cycle strobe; releases latched e-stop
- pwm_out  out  1  PWM output
- applied_width  out  16  width currently being generated, in us
- period_start  out  1  one-cycle pulse at the first clock of each period
- estop_latched  out  1  e-stop state flag

Behaviour:
- Reset values: pwm_out=0, applied_width=0, period_start=0, estop_latched=0, target=0, state=IDLE, all counters 0.
- Timebase:
  - Sub-module us_tick_gen divides clock by CLOCK_SPEED_HZ/1e6 and issues a 1-cycle us_tick.
  - The us counter runs 0..PERIOD_US-1 and wraps.
  - period_start is asserted in the clock cycle in which the counter wraps to 0 (and on the first tick after reset).
- Target latch:
  - On duty_valid, target <= clamp(duty, MIN_WIDTH_US, MAX_WIDTH_US). The comparison is signed 32-bit, so negative duty clamps to MIN.
  - Result is stored in 16 bits.
  - A duty_valid coincident with period_start is used for that period's update (bypass).
- States (updated only at period_start; estop checked every cycle):
  - IDLE: pwm_out=0. Goes to RUN at the next period_start after reset releases. applied_width <= MIN_WIDTH_US.
  - RUN: at period_start, nominal = mute ? clamp(zero_speed) : target; applied_width moves toward nominal.
  - ESTOP: pwm_out held 0 immediately; applied_width <= 0.
- E-stop:
  - emergency_off=1 in any state moves to ESTOP on the next clock (1-cycle latency) and sets estop_latched=1.
  - Exit only on clear_estop while emergency_off=0, to IDLE. clear_estop while emergency_off=1 is ignored.
  - Reset mid-ESTOP returns to IDLE with estop_latched=0.
  - If reset and emergency_off are both high, reset wins; ESTOP is entered on the first clock after reset drops.
- Output generation:
  - In RUN, pwm_out=1 while us counter < applied_width, else 0.
  - Width changes take effect only at period boundaries, so no runt pulses occur.
  - applied_width ≥ PERIOD_US (only possible via mis-parameterisation) is saturated to PERIOD_US-1.
- mute mid-period takes effect at the next period_start.

Optional Feature:
- Macro DUTY_SLEW_EN.
- Defined: at each period_start in RUN, applied_width moves toward nominal by min(|nominal-applied_width|, MAX_STEP_US). Equal values leave it unchanged. IDLE→RUN starts from MIN_WIDTH_US.
- Undefined: applied_width <= nominal directly at period_start. MAX_STEP_US is unused.

Decomposition:
- Package esc_pwm_pkg: state enum (IDLE, RUN, ESTOP), US_PER_S constant, and a clamp_width function (signed 32 in, 16-bit out).
- One sub-module, us_tick_gen (prescaler with synchronous reset), is natural. Everything else stays in esc_pwm_driver.

Test Plan:
- Reset, then duty=1500 with duty_valid: first RUN period is high 100 us (slew on: 104), converging by 4 us/period. Slew off: second period is high exactly 1500 us; period is 20000 us (1_000_000 clocks).
- duty=-50 → applied_width=100; duty=9000 → applied_width=2500 (slew off).
- mute=1 with zero_speed=330 while target=1500 → from next period, high time 330 us; mute=0 → returns to 1500.
- emergency_off pulsed mid-high-pulse → pwm_out=0 one clock later and estop_latched=1. clear_estop while emergency_off=1 has no effect. Clear after release → IDLE, then RUN at next period_start.
- duty_valid asserted in the same cycle as period_start with duty=700 → that period's high time is 700 us (slew off).
- reset asserted mid-pulse → pwm_out=0 and applied_width=0 the next clock; counters restart from 0.
